// File: rtl/ball_motion_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ball_motion_if: pixel stream in, ball position/miss pulses out   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface ball_motion_if;
    logic [25:0] strRGB_i;
    logic        run;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        miss_l;
    logic        miss_r;

    modport master (
        output strRGB_i, run,
        input  pos_x, pos_y, miss_l, miss_r
    );

    modport slave (
        input  strRGB_i, run,
        output pos_x, pos_y, miss_l, miss_r
    );
endinterface
`default_nettype wire

// File: rtl/ball_motion.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ball_motion: per-frame ball update with paddle/wall collisions   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ball_motion #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int SIZE_BALL    = 10,
    parameter int SPEED        = 2,
    parameter int X_INIT       = 315,
    parameter int Y_INIT       = 235,
    parameter int SERVE_FRAMES = 60
) (
    input  logic         px_clk,
    input  logic         reset_n,
    ball_motion_if.slave bus
);
    localparam logic [10:0] X_MAX      = 11'(H_ACTIVE - SIZE_BALL);
    localparam logic [10:0] Y_MAX      = 11'(V_ACTIVE - SIZE_BALL);
    localparam logic [10:0] SPD        = 11'(SPEED);
    localparam logic [10:0] SZ         = 11'(SIZE_BALL);
    localparam logic [10:0] XI         = 11'(X_INIT);
    localparam logic [10:0] YI         = 11'(Y_INIT);
    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        UPDATE = 2'd1,
        SERVE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  cur_x;
    logic [9:0]  cur_y;
    logic        dir_x;
    logic        dir_y;
    logic        hit_l;
    logic        hit_r;
    logic        hit_t;
    logic        hit_b;
    logic        vs_q;
    logic        armed;
    logic [7:0]  serve_cnt;
    logic        miss_l_q;
    logic        miss_r_q;

    logic [10:0] nx;
    logic [10:0] ny;
    logic        ndx;
    logic        ndy;
    logic        nml;
    logic        nmr;

    logic [2:0]  rgb;
    logic [10:0] sx;
    logic [10:0] sy;
    logic        act;
    logic        vs;
    logic [10:0] x11;
    logic [10:0] y11;
    logic        in_box;
    logic        frame_evt;
    logic        unused_bits;

    assign rgb = bus.strRGB_i[25:23];
    assign sx  = {1'b0, bus.strRGB_i[22:13]};
    assign sy  = {1'b0, bus.strRGB_i[12:3]};
    assign act = bus.strRGB_i[2];
    assign vs  = bus.strRGB_i[1];
    assign x11 = {1'b0, cur_x};
    assign y11 = {1'b0, cur_y};

    assign in_box = act && (rgb != 3'd0) &&
                    (sx > x11) && (sx < x11 + SZ) &&
                    (sy > y11) && (sy < y11 + SZ);

    // armed keeps a vsync that is already high when reset releases from counting
    assign frame_evt = armed && !vs_q && vs;

    assign unused_bits = ^{bus.strRGB_i[0], nx[10], ny[10]};

    always_comb begin
        state_nxt = state;
        nx        = x11;
        ny        = y11;
        ndx       = dir_x;
        ndy       = dir_y;
        nml       = 1'b0;
        nmr       = 1'b0;
        case (state)
            SCAN: begin
                if (frame_evt) state_nxt = UPDATE;
            end
            UPDATE: begin
                state_nxt = SCAN;
                if (bus.run) begin
                    if (!dir_x) begin
                        if (hit_l) begin
                            ndx = 1'b1;
                            nx  = (x11 + SPD > X_MAX) ? X_MAX : x11 + SPD;
                        end else if (x11 < SPD) begin
                            nml = 1'b1;
                            ndx = 1'b1;
                        end else begin
                            nx  = x11 - SPD;
                        end
                    end else begin
                        if (hit_r) begin
                            ndx = 1'b0;
                            nx  = (x11 < SPD) ? 11'd0 : x11 - SPD;
                        end else if (x11 + SPD > X_MAX) begin
                            nmr = 1'b1;
                            ndx = 1'b0;
                        end else begin
                            nx  = x11 + SPD;
                        end
                    end

                    if (nml || nmr) begin
                        state_nxt = SERVE;
                        nx        = XI;
                        ny        = YI;
                    end else if (!dir_y) begin
                        if (hit_t || y11 < SPD) begin
                            ndy = 1'b1;
                            ny  = (y11 + SPD > Y_MAX) ? Y_MAX : y11 + SPD;
                        end else begin
                            ny  = y11 - SPD;
                        end
                    end else begin
                        if (hit_b || y11 + SPD > Y_MAX) begin
                            ndy = 1'b0;
                            ny  = (y11 < SPD) ? 11'd0 : y11 - SPD;
                        end else begin
                            ny  = y11 + SPD;
                        end
                    end
                end
            end
            SERVE: begin
                if (frame_evt && serve_cnt == SERVE_LAST) state_nxt = SCAN;
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_x     <= XI[9:0];
            cur_y     <= YI[9:0];
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            miss_l_q  <= 1'b0;
            miss_r_q  <= 1'b0;
            vs_q      <= 1'b0;
            armed     <= 1'b0;
            serve_cnt <= 8'd0;
            hit_l     <= 1'b0;
            hit_r     <= 1'b0;
            hit_t     <= 1'b0;
            hit_b     <= 1'b0;
        end else begin
            cur_x    <= nx[9:0];
            cur_y    <= ny[9:0];
            dir_x    <= ndx;
            dir_y    <= ndy;
            miss_l_q <= nml;
            miss_r_q <= nmr;
            vs_q     <= vs;
            armed    <= armed | ~vs;

            if (state == SERVE) begin
                if (frame_evt) serve_cnt <= (serve_cnt == SERVE_LAST) ? 8'd0 : serve_cnt + 8'd1;
            end else begin
                serve_cnt <= 8'd0;
            end

            // flags only accumulate in SCAN; UPDATE clears them and SERVE keeps them low
            if (state == SCAN) begin
                if (in_box && sx == x11 + 11'd1)      hit_l <= 1'b1;
                if (in_box && sx == x11 + SZ - 11'd1) hit_r <= 1'b1;
                if (in_box && sy == y11 + 11'd1)      hit_t <= 1'b1;
                if (in_box && sy == y11 + SZ - 11'd1) hit_b <= 1'b1;
            end else begin
                hit_l <= 1'b0;
                hit_r <= 1'b0;
                hit_t <= 1'b0;
                hit_b <= 1'b0;
            end
        end
    end

    assign bus.pos_x  = cur_x;
    assign bus.pos_y  = cur_y;
    assign bus.miss_l = miss_l_q;
    assign bus.miss_r = miss_r_q;
endmodule
`default_nettype wire
